controlador_paridade: RTL and testbench
=======================================

CONTROLADOR_PARIDADE -- requirements
Module: controlador_paridade

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 2..32.
REQ-002 Parameter ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  source offers in_data.
REQ-006 Port in_ready  output  1  block can accept a word.
REQ-007 Port in_data  input  WIDTH  word whose parity is computed.
REQ-008 Port out_valid  output  1  result available.
REQ-009 Port out_ready  input  1  sink accepts the result.
REQ-010 Port out_data  output  WIDTH  copy of the accepted word.
REQ-011 Port out_parity  output  1  computed parity bit.
REQ-012 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL sequence a single 1-bit XOR stage serially, one data bit per clock; it SHALL NOT use a WIDTH-wide XOR reduction.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0.
- On in_valid&in_ready: capture in_data into the shift register and into out_data; acc<=ODD; count<=0; go to SHIFT.
REQ-016 SHIFT: in_ready=0.
- Each cycle: acc<=acc^shreg[0]; shreg shifts right by one; count increments.
- When count reaches WIDTH-1 in SHIFT: go to DONE on that edge.
- Result: exactly WIDTH XOR steps.
REQ-017 DONE: out_valid=1, out_parity=acc and out_data SHALL be held stable until out_valid&out_ready; on that edge go to IDLE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge.
- Throughput: at most one word per WIDTH+2 cycles.
REQ-019 in_valid while not in IDLE SHALL be ignored; no word is lost because in_ready=0 there.
REQ-020 out_ready while not in DONE SHALL have no effect.
REQ-021 out_ready held permanently at 1 SHALL cause DONE to last exactly one cycle.
REQ-022 The count register SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within a transaction.
REQ-023 out_parity SHALL equal ODD XOR (XOR of all bits of the accepted word).

Reset
REQ-024 rst_n=0 SHALL immediately force the following regardless of clk:
- state=IDLE; shreg=0; acc=0; count=0; out_data=0.
- Resulting outputs: in_ready=1, out_valid=0, out_parity=0, busy=0.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the transaction with no result presented; the first accept after release SHALL behave as from power-up.

Configuration
REQ-026 Macro PARIDADE_CHECK_EN; when defined, the block SHALL add:
- Port in_par  input  1  received parity bit, captured with in_data.
- Port par_err  output  1  asserted only in DONE, equal to in_par XOR out_parity.
- par_err SHALL reset to 0.
REQ-027 Without PARIDADE_CHECK_EN, ports in_par and par_err SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-028 WIDTH=8, ODD=0, in_data=8'hA5, out_ready=1 -> out_valid high 9 edges after accept; out_parity=0; out_data=8'hA5.
REQ-029 WIDTH=8, ODD=0, in_data=8'h07 -> out_parity=1. Same word with ODD=1 -> out_parity=0. ODD=1 with 8'h00 -> out_parity=1.
REQ-030 out_ready=0 for 5 cycles in DONE -> out_valid, out_parity and out_data stable for the whole stall. in_valid pulses during SHIFT and DONE are not accepted (in_ready=0).
REQ-031 rst_n pulsed low on the 3rd SHIFT cycle -> outputs take their reset values immediately, no out_valid follows, and the next word 8'hFF gives out_parity=0.
REQ-032 Back-to-back words 8'h01 then 8'h03 with in_valid and out_ready held at 1 -> results 1 then 0; second accept occurs on the first IDLE cycle.
REQ-033 With PARIDADE_CHECK_EN defined, in_data=8'h01 and in_par=0 -> par_err=1 in DONE. With in_par=1 -> par_err=0.

Source files
------------

// File: rtl/controlador_paridade.sv
// controlador_paridade: serial parity generator with a valid/ready handshake
// on both sides. A captured word is shifted out LSB first through a single
// 1-bit XOR accumulator, one bit per clock, then held in DONE until the sink
// takes it.
// Optional feature: define PARIDADE_CHECK_EN to add the in_par input and the
// par_err output, which compares a received parity bit with the computed one.
module controlador_paridade #(
    parameter int WIDTH = 8,   // data word width, 2..32
    parameter int ODD   = 0    // 0: even parity, 1: odd parity
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef PARIDADE_CHECK_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             busy
);

    // One extra bit lets count reach WIDTH without wrapping.
    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic            ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             acc;
    logic [CW-1:0]    count;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, WIDTH shift steps, hold DONE until taken.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a case arm leaves the state unchanged.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = SHIFT;
            SHIFT:   if (count == LAST) state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture on accept, one XOR step and one right shift per SHIFT cycle.
    // NOTE: these are plain registers, not a memory; they are reset because
    // out_data and out_parity are visible and must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            acc      <= 1'b0;
            count    <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        out_data <= in_data;
                        acc      <= ODD_BIT;
                        count    <= '0;
                    end
                end
                SHIFT: begin
                    acc   <= acc ^ shreg[0];
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // acc stops changing once DONE is reached, so it is the held result.
    assign out_parity = acc;

`ifdef PARIDADE_CHECK_EN
    logic in_par_q;

    // Received parity bit, captured alongside the data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        in_par_q <= 1'b0;
        else if (state == IDLE && in_valid) in_par_q <= in_par;
    end

    // Mismatch flag is only meaningful while the result is presented.
    always_comb begin
        par_err = (state == DONE) && (in_par_q ^ acc);
    end
`endif

endmodule

// File: tb/tb_controlador_paridade.sv
`timescale 1ns/1ps
// Testbench for controlador_paridade: an even-parity and an odd-parity
// instance share one stimulus stream; expected results are queued when a
// word is accepted and compared when each instance hands a result over.
module tb_controlador_paridade;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         parity;
        logic         perr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
`ifdef PARIDADE_CHECK_EN
    logic         in_par;
    logic         par_err0, par_err1;
`endif
    logic         in_ready0, out_valid0, out_parity0, busy0;
    logic [W-1:0] out_data0;
    logic         in_ready1, out_valid1, out_parity1, busy1;
    logic [W-1:0] out_data1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   outputs  = 0;

    always #5 clk = ~clk;

    controlador_paridade #(.WIDTH(W), .ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
`ifdef PARIDADE_CHECK_EN
        .in_par(in_par), .par_err(par_err0),
`endif
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_parity(out_parity0), .busy(busy0)
    );

    controlador_paridade #(.WIDTH(W), .ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
`ifdef PARIDADE_CHECK_EN
        .in_par(in_par), .par_err(par_err1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_parity(out_parity1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference parity: bitwise fold of the word, seeded with the ODD setting.
    function automatic logic model(input logic [W-1:0] d, input bit odd);
        logic p;
        p = odd;
        for (int i = 0; i < W; i++) p = p ^ d[i];
        return p;
    endfunction

    // Offer a word; returns after the accepting edge (+1ns). 'waited' counts
    // falling edges seen until in_ready was observed high.
    task automatic send_word(input logic [W-1:0] d, input logic p, input bit hold,
                             output int waited);
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
`ifdef PARIDADE_CHECK_EN
        in_par   = p;
`endif
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready0 && waited < 4 * W);
        check("accept_ready", in_ready0, 1);
        e.data   = d;
        e.parity = model(d, 1'b0);
        e.perr   = p ^ e.parity;
        q0.push_back(e);
        e.parity = model(d, 1'b1);
        e.perr   = p ^ e.parity;
        q1.push_back(e);
        pushed++;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q0.size() + q1.size(), 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: a result is taken on the edge following a falling-edge
    // sample that shows out_valid and out_ready both high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
            check("sb0_nonempty", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                outputs++;
                check("out_data0", out_data0, e0.data);
                check("out_parity0", out_parity0, e0.parity);
                check("busy0_done", busy0, 1);
`ifdef PARIDADE_CHECK_EN
                check("par_err0", par_err0, e0.perr);
`endif
            end
        end
        if (rst_n === 1'b1 && out_valid1 === 1'b1 && out_ready === 1'b1) begin
            check("sb1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("out_data1", out_data1, e1.data);
                check("out_parity1", out_parity1, e1.parity);
`ifdef PARIDADE_CHECK_EN
                check("par_err1", par_err1, e1.perr);
`endif
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int waited;
        int seen;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef PARIDADE_CHECK_EN
        in_par    = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #9;
        check("rst_in_ready",   in_ready0,   1);
        check("rst_out_valid",  out_valid0,  0);
        check("rst_busy",       busy0,       0);
        check("rst_out_parity", out_parity0, 0);
        check("rst_out_data",   out_data0,   0);
        check("rst_out_parity1", out_parity1, 0);
`ifdef PARIDADE_CHECK_EN
        check("rst_par_err", par_err0, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0xA5 with out_ready high. Latency counts edges with the accepting
        // edge as the first, up to and including the edge that raises out_valid.
        out_ready = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0, waited);
        check("busy_shift", busy0, 1);
        lat = 1;
        while (lat < 4 * W) begin
            @(negedge clk);
            if (out_valid0) break;
            lat++;
        end
        check("latency", lat, W + 1);
        check("a5_parity", out_parity0, 0);
        check("a5_data",   out_data0,   8'hA5);
        wait_drain(4 * W);

        // 0x07 and 0x00 on both parity senses.
        send_word(8'h07, 1'b0, 1'b0, waited);
        wait_drain(4 * W);
        send_word(8'h00, 1'b0, 1'b0, waited);
        wait_drain(4 * W);

        // Stall in DONE; words offered during SHIFT and DONE must be ignored.
        out_ready = 1'b0;
        send_word(8'h3C, 1'b0, 1'b0, waited);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        check("in_ready_shift", in_ready0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid0 && seen < 4 * W) begin
            @(negedge clk);
            seen++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_valid",  out_valid0,  1);
            check("stall_data",   out_data0,   8'h3C);
            check("stall_parity", out_parity0, 0);
            @(posedge clk); #1;
            in_valid = (k == 1);
            @(negedge clk);
            if (k == 1) check("in_ready_done", in_ready0, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(4 * W);
        repeat (2 * W) @(negedge clk);
        check("ignored_words", outputs, pushed);
        @(posedge clk); #1;

        // Reset on the third SHIFT cycle aborts the word.
        send_word(8'h5A, 1'b0, 1'b0, waited);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready",   in_ready0,   1);
        check("abort_out_valid",  out_valid0,  0);
        check("abort_busy",       busy0,       0);
        check("abort_out_parity", out_parity0, 0);
        check("abort_out_data",   out_data0,   0);
        void'(q0.pop_front());
        void'(q1.pop_front());
        pushed--;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        check("no_valid_after_abort", seen, 0);
        @(posedge clk); #1;
        send_word(8'hFF, 1'b0, 1'b0, waited);
        wait_drain(4 * W);

        // Back-to-back with in_valid held: second accept on first IDLE cycle.
        send_word(8'h01, 1'b0, 1'b1, waited);
        send_word(8'h03, 1'b0, 1'b0, waited);
        check("b2b_gap", waited, W + 2);
        wait_drain(4 * W);

`ifdef PARIDADE_CHECK_EN
        send_word(8'h01, 1'b0, 1'b0, waited);
        wait_drain(4 * W);
        send_word(8'h01, 1'b1, 1'b0, waited);
        wait_drain(4 * W);
`endif

        repeat (2) @(negedge clk);
        check("output_count", outputs, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
